// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the fetch sequencer: FSM
//                state encoding, default HALT encoding, counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Instruction encoding that stops fetch unless overridden at instantiation
  localparam logic [31:0] c_halt_instr_default = 32'hFFFF_FFFF;

  // Width of the performance counters
  localparam int PERF_CNT_WIDTH = 32;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_perf_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_perf_counter
//  Description : Saturating up-counter with synchronous clear and increment
//                enable. Clear takes priority over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_perf_counter
  import fetch_pkg::*;
#(
  parameter int WIDTH = PERF_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  // Count enabled events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule : fetch_perf_counter
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Fetch-stage controller. Owns the PC, addresses a
//                combinational-read instruction memory and registers the
//                returned word into the IF/ID boundary. Handles stalls,
//                branch redirects, HALT instructions and out-of-range targets.
//                Optional performance counters are built only when the macro
//                FETCH_PERF_CNT_EN is defined; otherwise the counter ports
//                read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                           PC_WIDTH          = 19,
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter int                           MEMORY_SIZE       = 1024,
  parameter int                           RESET_PC          = 0,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR        = INSTRUCTION_WIDTH'(c_halt_instr_default)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         stall_i,
  input  logic                         redirect_valid_i,
  input  logic [PC_WIDTH-1:0]          redirect_pc_i,
  output logic [PC_WIDTH-1:0]          pc_o,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  output logic [INSTRUCTION_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]          instr_pc_o,
  output logic                         instr_valid_o,
  output logic                         halted_o,
  output logic                         fault_o,
  output logic [PERF_CNT_WIDTH-1:0]    fetch_count_o,
  output logic [PERF_CNT_WIDTH-1:0]    stall_count_o
);

  localparam logic [PC_WIDTH-1:0] c_reset_pc     = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] c_last_pc      = PC_WIDTH'(MEMORY_SIZE - 1);
  // One extra bit so MEMORY_SIZE itself is representable for the range test
  localparam logic [PC_WIDTH:0]   c_mem_size_ext = (PC_WIDTH + 1)'(MEMORY_SIZE);

  fetch_state_t        r_state;
  logic                w_out_of_range;
  logic [PC_WIDTH-1:0] w_next_pc;

  assign w_out_of_range = ({1'b0, redirect_pc_i} >= c_mem_size_ext);
  assign w_next_pc      = (pc_o == c_last_pc) ? '0 : pc_o + PC_WIDTH'(1);

  // Fetch FSM; all IF/ID outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      pc_o          <= c_reset_pc;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      instr_valid_o <= 1'b0;
      halted_o      <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= RUN;
            pc_o    <= c_reset_pc;
          end
        end
        RUN: begin
          if (redirect_valid_i && w_out_of_range) begin
            r_state       <= HALT;
            halted_o      <= 1'b1;
            fault_o       <= 1'b1;
            instr_valid_o <= 1'b0;
          end else if (redirect_valid_i) begin
            // Redirect wins over stall; the word in flight is wrong-path
            pc_o          <= redirect_pc_i;
            instr_valid_o <= 1'b0;
          end else if (!stall_i) begin
            instr_o       <= instr_i;
            instr_pc_o    <= pc_o;
            instr_valid_o <= 1'b1;
            if (instr_i == HALT_INSTR) begin
              r_state  <= HALT;
              halted_o <= 1'b1;
            end else begin
              pc_o <= w_next_pc;
            end
          end
        end
        HALT: begin
          if (start_i) begin
            r_state       <= RUN;
            pc_o          <= c_reset_pc;
            halted_o      <= 1'b0;
            fault_o       <= 1'b0;
            instr_valid_o <= 1'b0;
          end else if (!stall_i) begin
            // Last issued word is consumed once decode accepts it
            instr_valid_o <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic w_cnt_clear;
  logic w_fetch_inc;
  logic w_stall_inc;

  // Start only clears when it is actually accepted (ignored while running)
  assign w_cnt_clear = start_i && (r_state != RUN);
  assign w_fetch_inc = (r_state == RUN) && !redirect_valid_i && !stall_i;
  assign w_stall_inc = (r_state == RUN) && !redirect_valid_i && stall_i;

  fetch_perf_counter #(
    .WIDTH (PERF_CNT_WIDTH)
  ) u_fetch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (w_cnt_clear),
    .inc_i   (w_fetch_inc),
    .count_o (fetch_count_o)
  );

  fetch_perf_counter #(
    .WIDTH (PERF_CNT_WIDTH)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (w_cnt_clear),
    .inc_i   (w_stall_inc),
    .count_o (stall_count_o)
  );
`else
  assign fetch_count_o = '0;
  assign stall_count_o = '0;
`endif

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. Directed scenarios
//                followed by randomized stimulus, all compared against a
//                cycle-level behavioural model of the fetch rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int          PCW    = 19;
  localparam int          MEMSZ  = 1024;
  localparam int          RSTPC  = 0;
  localparam logic [31:0] HALTW  = 32'hFFFF_FFFF;
  localparam longint      SATMAX = 64'h0000_0000_FFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic            stall_i;
  logic            redirect_valid_i;
  logic [PCW-1:0]  redirect_pc_i;
  logic [PCW-1:0]  pc_o;
  logic [31:0]     instr_i;
  logic [31:0]     instr_o;
  logic [PCW-1:0]  instr_pc_o;
  logic            instr_valid_o;
  logic            halted_o;
  logic            fault_o;
  logic [31:0]     fetch_count_o;
  logic [31:0]     stall_count_o;

  logic [31:0] mem [0:MEMSZ-1];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: mode 0 idle, 1 running, 2 halted
  int          m_mode;
  int          m_pc;
  logic [31:0] m_instr;
  int          m_ipc;
  bit          m_valid;
  bit          m_halted;
  bit          m_fault;
  longint      m_fc;
  longint      m_sc;

  always #5 clk = ~clk;

  assign instr_i = mem[pc_o[9:0]];

  fetch_sequencer #(
    .PC_WIDTH          (PCW),
    .INSTRUCTION_WIDTH (32),
    .MEMORY_SIZE       (MEMSZ),
    .RESET_PC          (RSTPC),
    .HALT_INSTR        (HALTW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_o             (pc_o),
    .instr_i          (instr_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_valid_o    (instr_valid_o),
    .halted_o         (halted_o),
    .fault_o          (fault_o),
    .fetch_count_o    (fetch_count_o),
    .stall_count_o    (stall_count_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RSTPC; m_instr = '0; m_ipc = 0;
    m_valid = 0; m_halted = 0; m_fault = 0; m_fc = 0; m_sc = 0;
  endtask

  // One clock of the fetch rules, using the memory word at the model PC
  task automatic model_step(input bit s, input bit st, input bit rv, input int rpc);
    logic [31:0] w;
    w = mem[m_pc];
    if (m_mode == 0) begin
      if (s) begin
        m_mode = 1; m_pc = RSTPC; m_fc = 0; m_sc = 0;
      end
    end else if (m_mode == 1) begin
      if (rv && rpc >= MEMSZ) begin
        m_mode = 2; m_halted = 1; m_fault = 1; m_valid = 0;
      end else if (rv) begin
        m_pc = rpc; m_valid = 0;
      end else if (st) begin
        if (m_sc < SATMAX) m_sc++;
      end else begin
        m_instr = w; m_ipc = m_pc; m_valid = 1;
        if (m_fc < SATMAX) m_fc++;
        if (w == HALTW) begin
          m_mode = 2; m_halted = 1;
        end else begin
          m_pc = (m_pc + 1) % MEMSZ;
        end
      end
    end else begin
      if (s) begin
        m_mode = 1; m_pc = RSTPC; m_halted = 0; m_fault = 0; m_valid = 0;
        m_fc = 0; m_sc = 0;
      end else if (!st) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    longint efc, esc;
`ifdef FETCH_PERF_CNT_EN
    efc = m_fc; esc = m_sc;
`else
    efc = 0; esc = 0;
`endif
    check({tag, ".pc"},     64'(pc_o),          64'(m_pc));
    check({tag, ".valid"},  64'(instr_valid_o), 64'(m_valid));
    check({tag, ".halted"}, 64'(halted_o),      64'(m_halted));
    check({tag, ".fault"},  64'(fault_o),       64'(m_fault));
    check({tag, ".instr"},  64'(instr_o),       64'(m_instr));
    check({tag, ".ipc"},    64'(instr_pc_o),    64'(m_ipc));
    check({tag, ".fcnt"},   64'(fetch_count_o), 64'(efc));
    check({tag, ".scnt"},   64'(stall_count_o), 64'(esc));
  endtask

  // Drive one cycle of inputs, advance the clock and compare after the edge
  task automatic step(input string tag, input bit s, input bit st, input bit rv, input int rpc);
    start_i = s; stall_i = st; redirect_valid_i = rv; redirect_pc_i = PCW'(rpc);
    @(posedge clk);
    model_step(s, st, rv, rpc);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset asserted away from any edge
  task automatic do_reset(input string tag);
    start_i = 0; stall_i = 0; redirect_valid_i = 0; redirect_pc_i = '0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(0, 0, 0, 0);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALTW) w = 32'h1234_5678;
    return w;
  endfunction

  logic [31:0] word_a, word_c;

  initial begin
    rst_n = 1'b0;
    start_i = 0; stall_i = 0; redirect_valid_i = 0; redirect_pc_i = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = rand_word();
    word_a = mem[0];
    word_c = mem[2];
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); model_step(0, 0, 0, 0); #1;
    step("idle_ignore", 0, 1, 1, 5);

    // Start and stream A, B, C
    step("start", 1, 0, 0, 0);
    check("start_pc", 64'(pc_o), 64'(RSTPC));
    step("fetchA", 0, 0, 0, 0);
    check("first_word", 64'(instr_o), 64'(word_a));
    step("fetchB", 0, 0, 0, 0);

    // Stall for three cycles holding B
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0);
    check("stall_hold_ipc", 64'(instr_pc_o), 64'd1);
    step("fetchC", 0, 0, 0, 0);
    check("after_stall", 64'(instr_o), 64'(word_c));

    // Redirect together with stall
    step("redir_stall", 0, 1, 1, 100);
    check("bubble", 64'(instr_valid_o), 64'd0);
    step("redir_tgt", 0, 0, 0, 0);
    check("redir_ipc", 64'(instr_pc_o), 64'd100);

    // Last legal PC then wrap to zero
    step("redir_last", 0, 0, 1, MEMSZ - 1);
    step("issue_last", 0, 0, 0, 0);
    check("last_ipc", 64'(instr_pc_o), 64'(MEMSZ - 1));
    step("issue_wrap", 0, 0, 0, 0);
    check("wrap_ipc", 64'(instr_pc_o), 64'd0);

    // Out-of-range redirect faults
    step("redir_oor", 0, 0, 1, MEMSZ);
    check("oor_fault", 64'({halted_o, fault_o, instr_valid_o}), 64'b110);
    step("halt_hold", 0, 0, 1, 7);
    step("restart", 1, 0, 0, 0);
    check("restart_flags", 64'({halted_o, fault_o}), 64'b00);

    // HALT word at PC 3
    mem[3] = HALTW;
    for (int i = 0; i < 4; i++) step("to_halt", 0, 0, 0, 0);
    check("halt_issue", 64'({instr_valid_o, halted_o}), 64'b11);
    check("halt_ipc", 64'(instr_pc_o), 64'd3);
    for (int i = 0; i < 3; i++) step("halted", 0, 0, 0, 0);
    check("halt_novalid", 64'(instr_valid_o), 64'd0);
    mem[3] = rand_word();

    // Reset in the middle of a run
    step("restart2", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("run", 0, 0, 0, 0);
    do_reset("midreset");

    // Randomized phase
    for (int i = 0; i < MEMSZ; i++)
      mem[i] = ($urandom_range(0, 49) == 0) ? HALTW : rand_word();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit s, st, rv;
      int rpc;
      s  = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: rpc = MEMSZ - 1;
        1: rpc = MEMSZ;
        2: rpc = $urandom_range(MEMSZ, (1 << PCW) - 1);
        default: rpc = $urandom_range(0, MEMSZ - 1);
      endcase
      if ($urandom_range(0, 599) == 0) do_reset("rnd_reset");
      else step("rnd", s, st, rv, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_sequencer
`default_nettype wire
